// File: rtl/data_memory_responder.sv
// Memory-side responder for the GPU data-memory interface: one request in flight,
// fixed LATENCY edges from acceptance to a one-cycle ready pulse.
module data_memory_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read_valid,
    input  logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_read_ready,
    output logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 mem_write_valid,
    input  logic [ADDR_BITS-1:0] mem_write_address,
    input  logic [DATA_BITS-1:0] mem_write_data,
    output logic                 mem_write_ready,
    output logic                 busy,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count
);

    localparam int unsigned DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

    state_t               state;
    logic [3:0]           counter;
    logic                 op_write;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] mem [DEPTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            counter         <= '0;
            op_write        <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            mem_read_ready  <= 1'b0;
            mem_read_data   <= '0;
            mem_write_ready <= 1'b0;
            read_count      <= '0;
            write_count     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // Read has priority; a concurrent write stays pending until after DONE.
                    if (mem_read_valid) begin
                        addr     <= mem_read_address;
                        op_write <= 1'b0;
                        counter  <= LAT_M1;
                        state    <= BUSY;
                    end else if (mem_write_valid) begin
                        addr     <= mem_write_address;
                        wdata    <= mem_write_data;
                        op_write <= 1'b1;
                        counter  <= LAT_M1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else if (op_write) begin
                        mem[addr]       <= wdata;
                        mem_write_ready <= 1'b1;
                        write_count     <= write_count + 16'd1;
                        state           <= RESP;
                    end else begin
                        mem_read_data  <= mem[addr];
                        mem_read_ready <= 1'b1;
                        read_count     <= read_count + 16'd1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    mem_read_ready  <= 1'b0;
                    mem_write_ready <= 1'b0;
                    state           <= DONE;
                end
                DONE: begin
                    // Wait for the serviced channel to release so the same request is not served twice.
                    if (op_write ? !mem_write_valid : !mem_read_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_data_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        rd_v, rd_rdy, wr_v, wr_rdy, busy;
    logic [7:0]  rd_a, wr_a;
    logic [15:0] rd_d, wr_d, rc, wc;

    logic        rd_v_1, rd_rdy_1, wr_v_1, wr_rdy_1, busy_1;
    logic [7:0]  rd_a_1, wr_a_1;
    logic [15:0] rd_d_1, wr_d_1, rc_1, wc_1;

    data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(16), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rd_v), .mem_read_address(rd_a), .mem_read_ready(rd_rdy), .mem_read_data(rd_d),
        .mem_write_valid(wr_v), .mem_write_address(wr_a), .mem_write_data(wr_d), .mem_write_ready(wr_rdy),
        .busy(busy), .read_count(rc), .write_count(wc)
    );

    data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(16), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rd_v_1), .mem_read_address(rd_a_1), .mem_read_ready(rd_rdy_1), .mem_read_data(rd_d_1),
        .mem_write_valid(wr_v_1), .mem_write_address(wr_a_1), .mem_write_data(wr_d_1), .mem_write_ready(wr_rdy_1),
        .busy(busy_1), .read_count(rc_1), .write_count(wc_1)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model [256];
    logic [15:0] rd_q [$];
    logic [15:0] exp_rc = 16'd0;
    logic [15:0] exp_wc = 16'd0;

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b required 0", name, busy);
        else n_pass++;
    endtask

    // Read on u0; expected data pushed at issue, popped on ready. hold = cycles valid stays high after ready.
    task automatic do_read(input logic [7:0] a, input int hold, output int lat);
        logic [15:0] e;
        int cyc;
        @(negedge clk);
        rd_v = 1'b1;
        rd_a = a;
        rd_q.push_back(model[a]);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rd_rdy && cyc < 40);
        n_checks++;
        if (rd_rdy !== 1'b1) $display("FAIL read_ready_timeout addr=%h: ready=%b required 1", a, rd_rdy);
        else n_pass++;
        e = rd_q.pop_front();
        n_checks++;
        if (rd_d !== e) $display("FAIL read_data addr=%h: got %h required %h", a, rd_d, e);
        else n_pass++;
        n_checks++;
        if (wr_rdy !== 1'b0) $display("FAIL ready_coincident: write_ready=%b required 0", wr_rdy);
        else n_pass++;
        exp_rc++;
        n_checks++;
        if (rc !== exp_rc) $display("FAIL read_count: got %0d required %0d", rc, exp_rc);
        else n_pass++;
        lat = cyc;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, rd_rdy} !== 2'b10)
                $display("FAIL hold_valid cycle %0d: busy,ready=%b required 10", i, {busy, rd_rdy});
            else n_pass++;
        end
        rd_v = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) $display("FAIL hold_release: busy=%b required 0", busy);
            else n_pass++;
        end
        wait_idle("read");
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, output int lat);
        int cyc;
        @(negedge clk);
        wr_v = 1'b1;
        wr_a = a;
        wr_d = d;
        model[a] = d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wr_rdy && cyc < 40);
        n_checks++;
        if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0)
            $display("FAIL write_ready addr=%h: wr,rd ready=%b required 10", a, {wr_rdy, rd_rdy});
        else n_pass++;
        exp_wc++;
        n_checks++;
        if (wc !== exp_wc) $display("FAIL write_count: got %0d required %0d", wc, exp_wc);
        else n_pass++;
        lat = cyc;
        @(negedge clk);
        n_checks++;
        if (wr_rdy !== 1'b0) $display("FAIL write_ready_width: ready=%b required 0", wr_rdy);
        else n_pass++;
        wr_v = 1'b0;
        wait_idle("write");
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b0;
        {rd_v, rd_a, wr_v, wr_a, wr_d} = '0;
        {rd_v_1, rd_a_1, wr_v_1, wr_a_1, wr_d_1} = '0;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_rdy, wr_rdy, busy, rc, wc, rd_d} !== '0)
            $display("FAIL reset_u0: outputs=%h required 0", {rd_rdy, wr_rdy, busy, rc, wc, rd_d});
        else n_pass++;
        n_checks++;
        if ({rd_rdy_1, wr_rdy_1, busy_1, rc_1, wc_1, rd_d_1} !== '0)
            $display("FAIL reset_u1: outputs=%h required 0", {rd_rdy_1, wr_rdy_1, busy_1, rc_1, wc_1, rd_d_1});
        else n_pass++;
        reset = 1'b1;
        do_read(8'h00, 0, lat);
    endtask

    task automatic test_write_latency();
        int lat;
        do_write(8'h0A, 16'h1234, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL write_latency: got %0d cycles required 3", lat);
        else n_pass++;
        do_read(8'h0A, 0, lat);
        n_checks++;
        if (lat !== 3) $display("FAIL read_latency: got %0d cycles required 3", lat);
        else n_pass++;
    endtask

    task automatic test_both_valid();
        logic [15:0] e;
        int cyc, lat;
        @(negedge clk);
        rd_v = 1'b1; rd_a = 8'h05;
        wr_v = 1'b1; wr_a = 8'h05; wr_d = 16'hBEEF;
        rd_q.push_back(model[8'h05]);
        model[8'h05] = 16'hBEEF;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rd_rdy && !wr_rdy && cyc < 40);
        n_checks++;
        if ({rd_rdy, wr_rdy} !== 2'b10) $display("FAIL both_priority: rd,wr ready=%b required 10", {rd_rdy, wr_rdy});
        else n_pass++;
        e = rd_q.pop_front();
        n_checks++;
        if (rd_d !== e) $display("FAIL both_old_data: got %h required %h", rd_d, e);
        else n_pass++;
        exp_rc++;
        rd_v = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (rd_rdy && wr_rdy) $display("FAIL both_coincident: rd,wr ready=11 required not both");
            else n_pass++;
        end while (!wr_rdy && cyc < 40);
        n_checks++;
        if (wr_rdy !== 1'b1) $display("FAIL both_write_follow: ready=%b required 1", wr_rdy);
        else n_pass++;
        exp_wc++;
        n_checks++;
        if ({rc, wc} !== {exp_rc, exp_wc}) $display("FAIL both_counts: got %h required %h", {rc, wc}, {exp_rc, exp_wc});
        else n_pass++;
        wr_v = 1'b0;
        wait_idle("both");
        do_read(8'h05, 0, lat);
    endtask

    task automatic test_hold_valid();
        int lat;
        do_read(8'h0A, 3, lat);
    endtask

    task automatic test_abort();
        int cyc, lat;
        logic [15:0] d;
        d = 16'($urandom);
        @(negedge clk);
        wr_v = 1'b1; wr_a = 8'hFF; wr_d = d;
        model[8'hFF] = d;
        @(negedge clk);
        wr_v = 1'b0;
        wr_d = ~d;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wr_rdy && cyc < 40);
        n_checks++;
        if (wr_rdy !== 1'b1) $display("FAIL abort_ready: ready=%b required 1", wr_rdy);
        else n_pass++;
        exp_wc++;
        n_checks++;
        if (wc !== exp_wc) $display("FAIL abort_count: got %0d required %0d", wc, exp_wc);
        else n_pass++;
        wait_idle("abort");
        do_read(8'hFF, 0, lat);
    endtask

    task automatic test_random();
        logic [7:0] a [4];
        int lat;
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'(8'h40 + 8'(i * 16) + 8'($urandom_range(0, 15)));
            do_write(a[i], 16'($urandom), lat);
        end
        for (int i = 3; i >= 0; i--) do_read(a[i], 0, lat);
    endtask

    task automatic read1(input logic [7:0] a, input logic [15:0] e, input string name);
        int cyc = 0;
        @(negedge clk);
        rd_v_1 = 1'b1; rd_a_1 = a;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rd_rdy_1 && cyc < 40);
        n_checks++;
        if (rd_rdy_1 !== 1'b1 || rd_d_1 !== e)
            $display("FAIL %s: ready=%b data=%h required ready=1 data=%h", name, rd_rdy_1, rd_d_1, e);
        else n_pass++;
        rd_v_1 = 1'b0;
        cyc = 0;
        while (busy_1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_latency1();
        int cyc = 0;
        @(negedge clk);
        wr_v_1 = 1'b1; wr_a_1 = 8'h20; wr_d_1 = 16'h0055;
        do begin
            @(negedge clk);
            cyc++;
        end while (!wr_rdy_1 && cyc < 40);
        n_checks++;
        if (cyc !== 2 || wr_rdy_1 !== 1'b1) $display("FAIL lat1_write: ready after %0d cycles required 2", cyc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_rdy_1 !== 1'b0) $display("FAIL lat1_width: ready=%b required 0", wr_rdy_1);
        else n_pass++;
        wr_v_1 = 1'b0;
        cyc = 0;
        while (busy_1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        read1(8'h20, 16'h0055, "lat1_read");

        // Reset while the write of 0x00AA to 0x10 is in BUSY.
        @(negedge clk);
        wr_v_1 = 1'b1; wr_a_1 = 8'h10; wr_d_1 = 16'h00AA;
        @(negedge clk);
        n_checks++;
        if (busy_1 !== 1'b1) $display("FAIL midop_busy: busy=%b required 1", busy_1);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rd_rdy_1, wr_rdy_1, busy_1, rc_1, wc_1, rd_d_1} !== '0)
            $display("FAIL midop_reset: outputs=%h required 0", {rd_rdy_1, wr_rdy_1, busy_1, rc_1, wc_1, rd_d_1});
        else n_pass++;
        wr_v_1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        read1(8'h10, 16'h0000, "midop_read");
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_both_valid();
        test_hold_valid();
        test_abort();
        test_random();
        test_latency1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
